// File: rtl/pingpong_width_down.sv
// pingpong_width_down
// Double-buffered wide-to-narrow width converter. A whole frame of up to
// NUM_WORDS x OUT_W bits is accepted in one beat into a free bank and is
// replayed as OUT_W-bit words over a valid/ready stream with an end-of-frame
// marker. Two banks let the next frame load while the current one drains.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   flush           synchronous clear of both banks and the output register
//   in_valid/ready  frame handshake (in_ready is registered)
//   in_data         frame payload, word i = in_data[i*OUT_W +: OUT_W]
//   in_len          valid words in frame (0 or >NUM_WORDS means NUM_WORDS)
//   out_valid/ready output word handshake
//   out_data        output word
//   out_last        final word of its frame
//   occupancy       banks holding undrained data (0..2)
//
// Configuration macro: PPWD_MSB_FIRST_EN
//   undefined: word 0 emitted first; defined: word len-1 emitted first.
module pingpong_width_down #(
    parameter int unsigned OUT_W     = 8,
    parameter int unsigned NUM_WORDS = 113,
    parameter int unsigned LEN_W     = $clog2(NUM_WORDS + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_WORDS*OUT_W-1:0] in_data,
    input  logic [LEN_W-1:0]           in_len,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_W-1:0]           out_data,
    output logic                       out_last,
    output logic [1:0]                 occupancy
);

    localparam int unsigned IN_W = NUM_WORDS * OUT_W;
    localparam int unsigned SH_W = $clog2(IN_W);
    localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(NUM_WORDS);

    logic [IN_W-1:0]  bank_data [2];
    logic [LEN_W-1:0] bank_len  [2];
    logic [1:0]       bank_valid;
    logic             wr_ptr;
    logic             rd_ptr;
    logic [LEN_W-1:0] rd_idx;

    logic [1:0]       bank_valid_n;
    logic             wr_ptr_n;
    logic             rd_ptr_n;
    logic [LEN_W-1:0] rd_idx_n;
    logic             out_valid_n;
    logic             out_last_n;
    logic [OUT_W-1:0] out_data_n;
    logic             in_ready_n;
    logic [1:0]       occupancy_n;

    logic             load_c;
    logic             fetch_c;
    logic [LEN_W-1:0] len_clamped;
    logic [LEN_W-1:0] cur_len;
    logic [LEN_W-1:0] word_sel;
    logic             cur_last;
    logic [OUT_W-1:0] cur_word;

    // Zero or oversize lengths mean a full bank.
    always_comb begin
        len_clamped = in_len;
        if (in_len == '0 || in_len > FULL_LEN) begin
            len_clamped = FULL_LEN;
        end
    end

    // Word selection from the bank being drained.
    always_comb begin
        cur_len  = bank_len[rd_ptr];
        cur_last = (rd_idx == cur_len - LEN_W'(1));
`ifdef PPWD_MSB_FIRST_EN
        word_sel = cur_len - LEN_W'(1) - rd_idx;
`else
        word_sel = rd_idx;
`endif
        cur_word = OUT_W'(bank_data[rd_ptr] >> (SH_W'(word_sel) * SH_W'(OUT_W)));
    end

    assign load_c  = in_valid && in_ready && !flush;
    assign fetch_c = (!out_valid || out_ready) && bank_valid[rd_ptr];

    // Next-state: fetch/release, drain, load, then flush overrides everything.
    always_comb begin
        bank_valid_n = bank_valid;
        wr_ptr_n     = wr_ptr;
        rd_ptr_n     = rd_ptr;
        rd_idx_n     = rd_idx;
        out_valid_n  = out_valid;
        out_last_n   = out_last;
        out_data_n   = out_data;

        if (fetch_c) begin
            out_valid_n = 1'b1;
            out_data_n  = cur_word;
            out_last_n  = cur_last;
            if (cur_last) begin
                bank_valid_n[rd_ptr] = 1'b0;
                rd_idx_n             = '0;
                rd_ptr_n             = ~rd_ptr;
            end else begin
                rd_idx_n = rd_idx + LEN_W'(1);
            end
        end else if (out_valid && out_ready) begin
            out_valid_n = 1'b0;
        end

        // Never collides with a release: the write bank was free.
        if (load_c) begin
            bank_valid_n[wr_ptr] = 1'b1;
            wr_ptr_n             = ~wr_ptr;
        end

        if (flush) begin
            bank_valid_n = '0;
            wr_ptr_n     = 1'b0;
            rd_ptr_n     = 1'b0;
            rd_idx_n     = '0;
            out_valid_n  = 1'b0;
            out_last_n   = 1'b0;
        end

        in_ready_n  = !bank_valid_n[wr_ptr_n];
        occupancy_n = {1'b0, bank_valid_n[0]} + {1'b0, bank_valid_n[1]};
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_valid  <= '0;
            bank_len[0] <= '0;
            bank_len[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            rd_idx      <= '0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            out_data    <= '0;
            in_ready    <= 1'b1;
            occupancy   <= '0;
        end else begin
            bank_valid <= bank_valid_n;
            wr_ptr     <= wr_ptr_n;
            rd_ptr     <= rd_ptr_n;
            rd_idx     <= rd_idx_n;
            out_valid  <= out_valid_n;
            out_last   <= out_last_n;
            out_data   <= out_data_n;
            in_ready   <= in_ready_n;
            occupancy  <= occupancy_n;
            if (load_c) begin
                bank_len[wr_ptr] <= len_clamped;
            end
        end
    end

    // Payload storage; contents are qualified by bank_valid so no reset.
    always_ff @(posedge clk) begin
        if (load_c) begin
            bank_data[wr_ptr] <= in_data;
        end
    end

endmodule
